// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe
// Description : Instruction decode stage with an 8-entry register file,
//               load-use hazard detection and the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [15:0]           instruc,
    input  logic [15:0]           seq_PC,
    input  logic [1:0]            w_reg_cont,
    input  logic                  ext_type,
    input  logic [1:0]            len_immed,
    input  logic                  mem_read,
    input  logic                  wb_en,
    input  logic [2:0]            wb_reg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  id_ready,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_data_1,
    output logic [DATA_WIDTH-1:0] ex_data_2,
    output logic [DATA_WIDTH-1:0] ex_ext,
    output logic [15:0]           ex_seq_PC,
    output logic [2:0]            ex_w_reg,
    output logic                  ex_mem_read,
    output logic [15:0]           stall_cnt
);

    localparam logic [15:0] c_stall_max = 16'hFFFF;

    logic [DATA_WIDTH-1:0] r_regs [0:7];
    logic                  r_ex_valid;
    logic [DATA_WIDTH-1:0] r_ex_data_1;
    logic [DATA_WIDTH-1:0] r_ex_data_2;
    logic [DATA_WIDTH-1:0] r_ex_ext;
    logic [15:0]           r_ex_seq_PC;
    logic [2:0]            r_ex_w_reg;
    logic                  r_ex_mem_read;
    logic [15:0]           r_stall_cnt;

    logic [2:0]            w_rs;
    logic [2:0]            w_rt;
    logic [DATA_WIDTH-1:0] w_rd_1;
    logic [DATA_WIDTH-1:0] w_rd_2;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [2:0]            w_wreg;
    logic                  w_ex_valid_eff;
    logic                  w_hazard;
    logic                  w_unused_instr;

    assign w_rs           = instruc[10:8];
    assign w_rt           = instruc[7:5];
    assign w_unused_instr = ^instruc[15:11];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en) begin
            r_regs[wb_reg] <= wb_data;
        end
    end

    always_comb begin
        w_rd_1 = r_regs[w_rs];
        w_rd_2 = r_regs[w_rt];
        if (BYPASS && wb_en && (wb_reg == w_rs)) w_rd_1 = wb_data;
        if (BYPASS && wb_en && (wb_reg == w_rt)) w_rd_2 = wb_data;
    end

    always_comb begin
        w_imm = '0;
        case (len_immed)
            2'b00:   w_imm = ext_type ? {{(DATA_WIDTH-5){instruc[4]}},   instruc[4:0]}
                                      : {{(DATA_WIDTH-5){1'b0}},         instruc[4:0]};
            2'b01:   w_imm = ext_type ? {{(DATA_WIDTH-8){instruc[7]}},   instruc[7:0]}
                                      : {{(DATA_WIDTH-8){1'b0}},         instruc[7:0]};
            2'b10:   w_imm = ext_type ? {{(DATA_WIDTH-11){instruc[10]}}, instruc[10:0]}
                                      : {{(DATA_WIDTH-11){1'b0}},        instruc[10:0]};
            default: w_imm = '0;
        endcase
    end

    always_comb begin
        w_wreg = 3'b111;
        case (w_reg_cont)
            2'b00:   w_wreg = instruc[7:5];
            2'b01:   w_wreg = instruc[4:2];
            2'b10:   w_wreg = instruc[10:8];
            default: w_wreg = 3'b111;
        endcase
    end

    // While reset is low the pipeline register is treated as empty, so the
    // handshake never reports a stale hazard.
    assign w_ex_valid_eff = r_ex_valid & rst;
    assign w_hazard = if_valid & w_ex_valid_eff & r_ex_mem_read &
                      ((r_ex_w_reg == w_rs) | (r_ex_w_reg == w_rt));
    assign id_ready = flush | (ex_ready & ~w_hazard);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_data_1   <= '0;
            r_ex_data_2   <= '0;
            r_ex_ext      <= '0;
            r_ex_seq_PC   <= '0;
            r_ex_w_reg    <= '0;
            r_ex_mem_read <= 1'b0;
            r_stall_cnt   <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (!ex_ready) begin
            r_ex_valid <= r_ex_valid;
        end else if (w_hazard) begin
            r_ex_valid <= 1'b0;
            if (r_stall_cnt != c_stall_max) r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
            r_ex_valid <= if_valid;
            if (if_valid) begin
                r_ex_data_1   <= w_rd_1;
                r_ex_data_2   <= w_rd_2;
                r_ex_ext      <= w_imm;
                r_ex_seq_PC   <= seq_PC;
                r_ex_w_reg    <= w_wreg;
                r_ex_mem_read <= mem_read;
            end
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_data_1   = r_ex_data_1;
    assign ex_data_2   = r_ex_data_2;
    assign ex_ext      = r_ex_ext;
    assign ex_seq_PC   = r_ex_seq_PC;
    assign ex_w_reg    = r_ex_w_reg;
    assign ex_mem_read = r_ex_mem_read;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_pipe
// Description : Directed self-checking bench for decode_pipe (BYPASS=1 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] instruc;
    logic [15:0] seq_PC;
    logic [1:0]  w_reg_cont;
    logic        ext_type;
    logic [1:0]  len_immed;
    logic        mem_read;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        ex_ready;
    logic        flush;

    logic        w_id_ready, w_ex_valid, w_ex_mem_read;
    logic [15:0] w_ex_data_1, w_ex_data_2, w_ex_ext, w_ex_seq_PC, w_stall_cnt;
    logic [2:0]  w_ex_w_reg;

    logic        w_nb_id_ready, w_nb_ex_valid, w_nb_ex_mem_read;
    logic [15:0] w_nb_ex_data_1, w_nb_ex_data_2, w_nb_ex_ext, w_nb_ex_seq_PC, w_nb_stall_cnt;
    logic [2:0]  w_nb_ex_w_reg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_pipe #(.DATA_WIDTH(16), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruc(instruc), .seq_PC(seq_PC),
        .w_reg_cont(w_reg_cont), .ext_type(ext_type), .len_immed(len_immed),
        .mem_read(mem_read), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .ex_ready(ex_ready), .flush(flush), .id_ready(w_id_ready), .ex_valid(w_ex_valid),
        .ex_data_1(w_ex_data_1), .ex_data_2(w_ex_data_2), .ex_ext(w_ex_ext),
        .ex_seq_PC(w_ex_seq_PC), .ex_w_reg(w_ex_w_reg), .ex_mem_read(w_ex_mem_read),
        .stall_cnt(w_stall_cnt)
    );

    decode_pipe #(.DATA_WIDTH(16), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .if_valid(if_valid), .instruc(instruc), .seq_PC(seq_PC),
        .w_reg_cont(w_reg_cont), .ext_type(ext_type), .len_immed(len_immed),
        .mem_read(mem_read), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .ex_ready(ex_ready), .flush(flush), .id_ready(w_nb_id_ready), .ex_valid(w_nb_ex_valid),
        .ex_data_1(w_nb_ex_data_1), .ex_data_2(w_nb_ex_data_2), .ex_ext(w_nb_ex_ext),
        .ex_seq_PC(w_nb_ex_seq_PC), .ex_w_reg(w_nb_ex_w_reg), .ex_mem_read(w_nb_ex_mem_read),
        .stall_cnt(w_nb_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [15:0] ins, input logic [15:0] pc,
                           input logic [1:0] wrc, input logic ld);
        if_valid   = 1'b1;
        instruc    = ins;
        seq_PC     = pc;
        w_reg_cont = wrc;
        mem_read   = ld;
    endtask

    initial begin
        rst = 1'b0; if_valid = 1'b0; instruc = '0; seq_PC = '0; w_reg_cont = '0;
        ext_type = 1'b0; len_immed = '0; mem_read = 1'b0; wb_en = 1'b0; wb_reg = '0;
        wb_data = '0; ex_ready = 1'b1; flush = 1'b0;
        step();
        check("rst_ex_valid", {31'd0, w_ex_valid}, 32'd0);
        check("rst_data_1", {16'd0, w_ex_data_1}, 32'd0);
        check("rst_ext", {16'd0, w_ex_ext}, 32'd0);
        check("rst_stall", {16'd0, w_stall_cnt}, 32'd0);
        check("rst_id_ready", {31'd0, w_id_ready}, 32'd1);

        // Writeback r3 then read it through rs
        rst = 1'b1; wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'h1234;
        step();
        wb_en = 1'b0;
        present(16'h0314, 16'h0102, 2'b01, 1'b0);
        step();
        check("rf_valid", {31'd0, w_ex_valid}, 32'd1);
        check("rf_data_1", {16'd0, w_ex_data_1}, 32'h1234);
        check("rf_seq_pc", {16'd0, w_ex_seq_PC}, 32'h0102);
        check("rf_w_reg", {29'd0, w_ex_w_reg}, 32'd5);

        // Same-edge writeback and read of r2
        if_valid = 1'b0; wb_en = 1'b1; wb_reg = 3'd2; wb_data = 16'h1111;
        step();
        wb_data = 16'hBEEF;
        present(16'h0040, 16'h0104, 2'b00, 1'b0);
        step();
        check("byp1_data_2", {16'd0, w_ex_data_2}, 32'hBEEF);
        check("byp0_data_2", {16'd0, w_nb_ex_data_2}, 32'h1111);
        wb_en = 1'b0;
        step();
        check("byp0_after", {16'd0, w_nb_ex_data_2}, 32'hBEEF);

        // Immediate lengths / extension and write-register select
        ext_type = 1'b1; len_immed = 2'b01;
        present(16'h0080, 16'h0106, 2'b00, 1'b0);
        step();
        check("imm8_sext", {16'd0, w_ex_ext}, 32'hFF80);
        check("wreg_rt", {29'd0, w_ex_w_reg}, 32'd4);
        ext_type = 1'b0;
        step();
        check("imm8_zext", {16'd0, w_ex_ext}, 32'h0080);
        ext_type = 1'b1; len_immed = 2'b00;
        present(16'h0310, 16'h0108, 2'b10, 1'b0);
        step();
        check("imm5_sext", {16'd0, w_ex_ext}, 32'hFFF0);
        check("wreg_rs", {29'd0, w_ex_w_reg}, 32'd3);
        len_immed = 2'b10;
        present(16'h0400, 16'h010A, 2'b11, 1'b0);
        step();
        check("imm11_sext", {16'd0, w_ex_ext}, 32'hFC00);
        check("wreg_r7", {29'd0, w_ex_w_reg}, 32'd7);
        len_immed = 2'b11;
        present(16'hFFFF, 16'h010C, 2'b00, 1'b0);
        step();
        check("imm_zero", {16'd0, w_ex_ext}, 32'h0000);
        len_immed = 2'b00; ext_type = 1'b0;

        // Load r4, then a reader of r4 through rs
        present(16'h0010, 16'h0110, 2'b01, 1'b1);
        step();
        check("ld_mem_read", {31'd0, w_ex_mem_read}, 32'd1);
        present(16'h0438, 16'h0200, 2'b01, 1'b0);
        #1;
        check("lu_id_ready", {31'd0, w_id_ready}, 32'd0);
        step();
        check("lu_bubble", {31'd0, w_ex_valid}, 32'd0);
        check("lu_stall", {16'd0, w_stall_cnt}, 32'd1);
        check("lu_hold_wreg", {29'd0, w_ex_w_reg}, 32'd4);
        check("lu_id_ready2", {31'd0, w_id_ready}, 32'd1);
        step();
        check("lu_capture", {31'd0, w_ex_valid}, 32'd1);
        check("lu_cap_pc", {16'd0, w_ex_seq_PC}, 32'h0200);

        // Load r1, then a reader of r1 through rt
        present(16'h0004, 16'h0210, 2'b01, 1'b1);
        step();
        present(16'h0028, 16'h0212, 2'b01, 1'b0);
        #1;
        check("lu_rt_ready", {31'd0, w_id_ready}, 32'd0);
        step();
        check("lu_rt_stall", {16'd0, w_stall_cnt}, 32'd2);
        step();

        // Hold for three cycles, then flush
        present(16'h0000, 16'h0300, 2'b00, 1'b0);
        step();
        present(16'h0000, 16'h0400, 2'b00, 1'b0);
        ex_ready = 1'b0;
        #1;
        check("hold_id_ready", {31'd0, w_id_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pc", {16'd0, w_ex_seq_PC}, 32'h0300);
            check("hold_valid", {31'd0, w_ex_valid}, 32'd1);
        end
        flush = 1'b1;
        #1;
        check("flush_id_ready", {31'd0, w_id_ready}, 32'd1);
        step();
        check("flush_valid", {31'd0, w_ex_valid}, 32'd0);
        check("flush_pc", {16'd0, w_ex_seq_PC}, 32'h0300);
        flush = 1'b0; ex_ready = 1'b1;

        // Saturation: preload the counter near its ceiling
        force dut.r_stall_cnt = 16'hFFFE;
        #1;
        release dut.r_stall_cnt;
        present(16'h0410, 16'h0500, 2'b01, 1'b1);
        step();
        step();
        check("sat_first", {16'd0, w_stall_cnt}, 32'hFFFF);
        step();
        step();
        check("sat_hold", {16'd0, w_stall_cnt}, 32'hFFFF);
        check("sat_bubble", {31'd0, w_ex_valid}, 32'd0);

        // Reset in the middle of a stall, with a suppressed writeback
        step();
        check("mid_stall_ready", {31'd0, w_id_ready}, 32'd0);
        rst = 1'b0; wb_en = 1'b1; wb_reg = 3'd5; wb_data = 16'hAAAA;
        #1;
        check("rst_stall_ready", {31'd0, w_id_ready}, 32'd1);
        step();
        check("rst2_valid", {31'd0, w_ex_valid}, 32'd0);
        check("rst2_stall", {16'd0, w_stall_cnt}, 32'd0);
        check("rst2_pc", {16'd0, w_ex_seq_PC}, 32'd0);
        check("rst2_w_reg", {29'd0, w_ex_w_reg}, 32'd0);
        check("rst2_mem_read", {31'd0, w_ex_mem_read}, 32'd0);
        check("rst2_data_1", {16'd0, w_ex_data_1}, 32'd0);
        rst = 1'b1; wb_en = 1'b0;
        present(16'h0500, 16'h0600, 2'b01, 1'b0);
        step();
        check("rst_wr_suppressed", {16'd0, w_ex_data_1}, 32'd0);
        check("post_rst_valid", {31'd0, w_ex_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, register/data/immediate width; legal values are 16 or greater.
REQ-002 SHALL provide parameter BYPASS, default 1; 1 enables write-to-read bypass in the register file.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 if_valid  input  1  instruc/seq_PC hold a valid instruction.
REQ-007 instruc  input  16  instruction: rs=[10:8], rt=[7:5], rd=[4:2].
REQ-008 seq_PC  input  16  PC+2 of the instruction.
REQ-009 w_reg_cont  input  2  write-register select.
REQ-010 ext_type  input  1  1=sign-extend, 0=zero-extend.
REQ-011 len_immed  input  2  immediate length select.
REQ-012 mem_read  input  1  the instruction is a load.
REQ-013 wb_en, wb_reg, wb_data  input  1/3/DATA_WIDTH  writeback port.
REQ-014 ex_ready  input  1  downstream accepts this cycle.
REQ-015 flush  input  1  discard the instruction in decode and the ID/EX register.
REQ-016 id_ready  output  1  decode consumes instruc this cycle.
REQ-017 ex_valid  output  1  ID/EX register holds a valid instruction.
REQ-018 ex_data_1, ex_data_2, ex_ext  output  DATA_WIDTH each  registered rs data, rt data and immediate.
REQ-019 ex_seq_PC, ex_w_reg, ex_mem_read  output  16/3/1  registered payload.
REQ-020 stall_cnt  output  16  count of load-use bubbles.

Function
REQ-021 Register file SHALL hold 8 x DATA_WIDTH entries and write wb_data to wb_reg on the rising edge when wb_en=1 and rst=1.
REQ-022 Reads SHALL be combinational on rs and rt; with BYPASS=1, a read whose address matches wb_reg while wb_en=1 SHALL return wb_data; with BYPASS=0 it SHALL return the old contents.
REQ-023 The immediate SHALL be selected by len_immed: 00 uses [4:0], 01 uses [7:0], 10 uses [10:0], and 11 gives zero; it is then extended to DATA_WIDTH per ext_type.
REQ-024 The write-register SHALL be selected by w_reg_cont: 00 gives [7:5], 01 gives [4:2], 10 gives [10:8], and 11 gives 3'b111.
REQ-025 hazard SHALL be 1 when if_valid=1, ex_valid=1, ex_mem_read=1 and ex_w_reg equals rs or rt; both fields are compared for every opcode.
REQ-026 id_ready SHALL equal flush OR (ex_ready AND NOT hazard), combinationally.
REQ-027 Priority at each rising edge SHALL be: reset, then flush, then hold, then bubble, then capture.
REQ-028 On flush=1, ex_valid SHALL be set to 0; the payload SHALL hold.
REQ-029 On ex_ready=0 with no flush, all ID/EX state SHALL hold.
REQ-030 On ex_ready=1 with hazard=1, ex_valid SHALL be set to 0, the payload SHALL hold, and stall_cnt SHALL increment.
REQ-031 On ex_ready=1 with hazard=0, ex_valid SHALL load if_valid; when if_valid=1, the payload SHALL load the REQ-022..024 results and seq_PC/mem_read.
REQ-032 Latency from a consumed instruction to ex_valid=1 SHALL be 1 cycle.
REQ-033 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-034 A simultaneous writeback and capture on the same edge SHALL deliver the bypassed value when BYPASS=1.

Reset
REQ-035 At a rising edge with rst=0, the block SHALL clear all 8 registers, ex_valid, every payload output and stall_cnt to 0.
REQ-036 Register writes SHALL be suppressed on reset edges.
REQ-037 During reset cycles id_ready SHALL follow REQ-026 with ex_valid=0.
REQ-038 Reset asserted mid-stall SHALL clear the bubble state, and the stalled instruction SHALL be re-presented by fetch.

Verification
REQ-039 Writeback r3=16'h1234, then decode with rs=3 -> ex_data_1=16'h1234 one cycle later with ex_valid=1.
REQ-040 Same-cycle wb_en with wb_reg=2, wb_data=16'hBEEF and rt=2 under BYPASS=1 -> ex_data_2=16'hBEEF; under BYPASS=0 -> ex_data_2 holds the prior r2 value.
REQ-041 A load writing r4 in ID/EX followed by an instruction reading r4 -> id_ready=0 for one cycle, one bubble, stall_cnt=1, then capture.
REQ-042 len_immed=01, ext_type=1, instruc[7:0]=8'h80 -> ex_ext=16'hFF80; the same with ext_type=0 -> 16'h0080.
REQ-043 ex_ready=0 for 3 cycles, then flush with if_valid=1 -> payload held, then ex_valid=0 next cycle, and id_ready=1 during flush.
REQ-044 stall_cnt preloaded by 65535 hazards, then one more hazard -> stall_cnt stays 16'hFFFF; rst=0 -> all outputs 0.
